// File: rtl/latch_loader.sv
// latch_loader: registers a producer word and drives a bank of transparent
// D-latches with a c pulse framed by setup and hold intervals on d.
module latch_loader #(
   parameter int unsigned W       = 8,
   parameter int unsigned T_SETUP = 1,
   parameter int unsigned T_PULSE = 2,
   parameter int unsigned T_HOLD  = 1,
   parameter int unsigned CW      = 8
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          dav_,
   input  logic [W-1:0]  data_in,
   output logic          rfd,
   output logic [W-1:0]  d,
   output logic          c,
   output logic [CW-1:0] loads
);

   // One phase counter shared by setup, pulse and hold intervals.
   localparam int unsigned TSP  = (T_SETUP > T_PULSE) ? T_SETUP : T_PULSE;
   localparam int unsigned TMAX = (TSP > T_HOLD) ? TSP : T_HOLD;
   localparam int unsigned PW   = $clog2(TMAX + 1);

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_SETUP = 3'd1;
   localparam logic [2:0] ST_PULSE = 3'd2;
   localparam logic [2:0] ST_HOLD  = 3'd3;
   localparam logic [2:0] ST_WAIT  = 3'd4;

   logic [2:0]    state;
   logic [2:0]    state_nx;
   logic [PW-1:0] cnt;
   logic [PW-1:0] cnt_nx;
   logic [W-1:0]  d_nx;
   logic          c_nx;
   logic          rfd_nx;
   logic [CW-1:0] loads_nx;

   // State, phase counter and all outputs are registered; reset aborts any load.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= ST_IDLE;
         cnt   <= '0;
         d     <= '0;
         c     <= 1'b0;
         rfd   <= 1'b1;
         loads <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         d     <= d_nx;
         c     <= c_nx;
         rfd   <= rfd_nx;
         loads <= loads_nx;
      end
   end

   // Next-state and next-output logic for the load sequence.
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      d_nx     = d;
      c_nx     = c;
      rfd_nx   = rfd;
      loads_nx = loads;
      case (state)
         ST_IDLE: begin
            c_nx   = 1'b0;
            rfd_nx = 1'b1;
            if (!dav_) begin
               d_nx     = data_in;
               rfd_nx   = 1'b0;
               cnt_nx   = PW'(T_SETUP - 1);
               state_nx = ST_SETUP;
            end
         end
         ST_SETUP: begin
            if (cnt == '0) begin
               c_nx     = 1'b1;
               cnt_nx   = PW'(T_PULSE - 1);
               state_nx = ST_PULSE;
            end else begin
               cnt_nx = cnt - PW'(1);
            end
         end
         ST_PULSE: begin
            if (cnt == '0) begin
               c_nx     = 1'b0;
               cnt_nx   = PW'(T_HOLD - 1);
               state_nx = ST_HOLD;
            end else begin
               cnt_nx = cnt - PW'(1);
            end
         end
         ST_HOLD: begin
            if (cnt == '0) begin
               loads_nx = loads + CW'(1);
               state_nx = ST_WAIT;
            end else begin
               cnt_nx = cnt - PW'(1);
            end
         end
         ST_WAIT: begin
            rfd_nx = 1'b0;
            if (dav_) begin
               rfd_nx   = 1'b1;
               state_nx = ST_IDLE;
            end
         end
         default: begin
            c_nx     = 1'b0;
            rfd_nx   = 1'b1;
            state_nx = ST_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_latch_loader.sv
// Scoreboard bench for latch_loader: three instances (default timing,
// stretched timing, 2-bit load counter) each feeding a latch-bank model.
module tb_latch_loader;

   logic clock = 1'b0;
   logic reset = 1'b0;

   logic       dav0 = 1'b1, dav1 = 1'b1, dav2 = 1'b1;
   logic [7:0] data0 = '0, data1 = '0, data2 = '0;
   logic       rfd0, rfd1, rfd2;
   logic [7:0] d0, d1, d2;
   logic       c0, c1, c2;
   logic [7:0] loads0, loads1;
   logic [1:0] loads2;

   latch_loader u0 (.clock(clock), .reset(reset), .dav_(dav0), .data_in(data0),
                    .rfd(rfd0), .d(d0), .c(c0), .loads(loads0));
   latch_loader #(.T_SETUP(2), .T_PULSE(3), .T_HOLD(2)) u1 (
                    .clock(clock), .reset(reset), .dav_(dav1), .data_in(data1),
                    .rfd(rfd1), .d(d1), .c(c1), .loads(loads1));
   latch_loader #(.CW(2)) u2 (.clock(clock), .reset(reset), .dav_(dav2), .data_in(data2),
                    .rfd(rfd2), .d(d2), .c(c2), .loads(loads2));

   always #5 clock = ~clock;

   // Transparent latch bank models.
   logic [7:0] lq0, lq1, lq2;
   always @* if (c0) lq0 = d0;
   always @* if (c1) lq1 = d1;
   always @* if (c2) lq2 = d2;

   logic       c_a[3];
   logic       rfd_a[3];
   logic [7:0] d_a[3];
   logic [7:0] ld_a[3];
   logic [7:0] lq_a[3];
   assign c_a[0] = c0;   assign c_a[1] = c1;   assign c_a[2] = c2;
   assign rfd_a[0] = rfd0; assign rfd_a[1] = rfd1; assign rfd_a[2] = rfd2;
   assign d_a[0] = d0;   assign d_a[1] = d1;   assign d_a[2] = d2;
   assign ld_a[0] = loads0; assign ld_a[1] = loads1; assign ld_a[2] = {6'b0, loads2};
   assign lq_a[0] = lq0; assign lq_a[1] = lq1; assign lq_a[2] = lq2;

   int tset[3] = '{1, 2, 1};
   int tpul[3] = '{2, 3, 2};
   int thld[3] = '{1, 2, 1};

   logic [7:0] exp_data[3][$];
   logic [7:0] exp_loads[3][$];

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic wait_rfd(input int i);
      int n = 0;
      while (rfd_a[i] !== 1'b1 && n < 100) begin
         tick();
         n++;
      end
      check($sformatf("rfd_ready%0d", i), 32'(rfd_a[i]), 32'd1);
   endtask

   // Monitor: checks pulse framing and pops expected values on each completed load.
   logic cp[3];
   logic [7:0] dp[3];
   logic [7:0] lp[3];
   int stab[3], since[3], hi[3];
   always @(negedge clock) begin
      for (int i = 0; i < 3; i++) begin
         if (reset) begin
            cp[i] = 1'b0; dp[i] = d_a[i]; lp[i] = ld_a[i];
            stab[i] = 0; since[i] = 1000; hi[i] = 0;
         end else begin
            since[i] = since[i] + 1;
            if (d_a[i] != dp[i]) begin
               check($sformatf("hold%0d", i), 32'(since[i] >= thld[i]), 32'd1);
               stab[i] = 0;
            end else begin
               stab[i] = stab[i] + 1;
            end
            if (c_a[i] && !cp[i]) begin
               check($sformatf("setup%0d", i), 32'(stab[i] >= tset[i]), 32'd1);
               hi[i] = 1;
            end else if (c_a[i]) begin
               hi[i] = hi[i] + 1;
            end
            if (!c_a[i] && cp[i]) begin
               since[i] = 0;
               check($sformatf("width%0d", i), 32'(hi[i]), 32'(tpul[i]));
               check($sformatf("pulse_expected%0d", i), 32'(exp_data[i].size() > 0), 32'd1);
               if (exp_data[i].size() > 0)
                  check($sformatf("latched%0d", i), 32'(lq_a[i]), 32'(exp_data[i].pop_front()));
            end
            if (ld_a[i] != lp[i]) begin
               check($sformatf("load_expected%0d", i), 32'(exp_loads[i].size() > 0), 32'd1);
               if (exp_loads[i].size() > 0)
                  check($sformatf("loads%0d", i), 32'(ld_a[i]), 32'(exp_loads[i].pop_front()));
            end
            cp[i] = c_a[i]; dp[i] = d_a[i]; lp[i] = ld_a[i];
         end
      end
   end

   // Watchdog so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   logic [7:0] wrap_exp[5] = '{8'd1, 8'd2, 8'd3, 8'd0, 8'd1};

   // Directed stimulus.
   initial begin
      #2 reset = 1'b1;
      tick(); tick();
      reset = 1'b0;
      check("rst_rfd", 32'(rfd0), 32'd1);
      check("rst_c", 32'(c0), 32'd0);
      check("rst_d", 32'(d0), 32'h00);
      check("rst_loads", 32'(loads0), 32'd0);

      // Reset in the middle of a pulse.
      dav0 = 1'b0; data0 = 8'hA5;
      tick();
      dav0 = 1'b1;
      check("abort_d", 32'(d0), 32'hA5);
      tick();
      check("abort_c_high", 32'(c0), 32'd1);
      #2 reset = 1'b1;
      #1;
      check("abort_c", 32'(c0), 32'd0);
      check("abort_rfd", 32'(rfd0), 32'd1);
      check("abort_dclr", 32'(d0), 32'h00);
      check("abort_loads", 32'(loads0), 32'd0);
      tick();
      reset = 1'b0;
      tick();
      check("post_rst_rfd", 32'(rfd0), 32'd1);
      check("post_rst_c", 32'(c0), 32'd0);

      // Basic load, default timing.
      exp_data[0].push_back(8'h3C); exp_loads[0].push_back(8'd1);
      dav0 = 1'b0; data0 = 8'h3C;
      tick();                                   // edge 0
      check("basic_d", 32'(d0), 32'h3C);
      check("basic_rfd0", 32'(rfd0), 32'd0);
      check("basic_c_e0", 32'(c0), 32'd0);
      tick();                                   // edge 1
      check("basic_c_e1", 32'(c0), 32'd1);
      dav0 = 1'b1;
      tick();                                   // edge 2
      check("basic_c_e2", 32'(c0), 32'd1);
      tick();                                   // edge 3
      check("basic_c_e3", 32'(c0), 32'd0);
      check("basic_loads_e3", 32'(loads0), 32'd0);
      tick();                                   // edge 4
      check("basic_loads_e4", 32'(loads0), 32'd1);
      check("basic_rfd_e4", 32'(rfd0), 32'd0);
      tick();                                   // edge 5
      check("basic_rfd_e5", 32'(rfd0), 32'd1);

      // Slow producer holds dav_ low for 20 cycles.
      exp_data[0].push_back(8'h5A); exp_loads[0].push_back(8'd2);
      dav0 = 1'b0; data0 = 8'h5A;
      for (int n = 0; n < 20; n++) tick();
      check("slow_rfd_low", 32'(rfd0), 32'd0);
      dav0 = 1'b1;
      tick();
      check("slow_rfd_back", 32'(rfd0), 32'd1);
      check("slow_loads", 32'(loads0), 32'd2);

      // data_in changes during the pulse must not reach d.
      exp_data[0].push_back(8'h11); exp_loads[0].push_back(8'd3);
      dav0 = 1'b0; data0 = 8'h11;
      tick();
      dav0 = 1'b1;
      tick();
      data0 = 8'hFF;
      tick();
      check("chg_d_pulse", 32'(d0), 32'h11);
      tick();
      check("chg_d_hold", 32'(d0), 32'h11);
      tick();
      check("chg_d_wait", 32'(d0), 32'h11);
      check("chg_latch", 32'(lq0), 32'h11);
      wait_rfd(0);

      // Back-to-back loads with stretched timing.
      for (int v = 0; v < 10; v++) begin
         wait_rfd(1);
         exp_data[1].push_back(8'(v)); exp_loads[1].push_back(8'(v + 1));
         dav1 = 1'b0; data1 = 8'(v);
         tick();
         dav1 = 1'b1;
      end
      wait_rfd(1);
      check("b2b_loads", 32'(loads1), 32'd10);
      check("b2b_last_latch", 32'(lq1), 32'd9);

      // Load counter wrap with a 2-bit counter.
      for (int n = 0; n < 5; n++) begin
         wait_rfd(2);
         exp_data[2].push_back(8'h20 + 8'(n)); exp_loads[2].push_back(wrap_exp[n]);
         dav2 = 1'b0; data2 = 8'h20 + 8'(n);
         tick();
         dav2 = 1'b1;
      end
      wait_rfd(2);
      check("wrap_loads", 32'(loads2), 32'd1);

      tick(); tick();
      for (int i = 0; i < 3; i++) begin
         check($sformatf("data_q_drained%0d", i), 32'(exp_data[i].size()), 32'd0);
         check($sformatf("loads_q_drained%0d", i), 32'(exp_loads[i].size()), 32'd0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
